picorv32_trace_capture: RTL and testbench

- Wishbone-readable capture buffer for the picorv32 36-bit instruction trace stream.
- Sits beside the core in the demo system: consumes `trace_valid`/`trace_data` and `trap`, and stores samples in an on-chip FIFO.
- Firmware or a debug master drains the FIFO over a classic Wishbone slave port, so the trace is available on hardware without a simulator file dump.

---
 rtl/picorv32_trace_capture.sv | 238 +++++++++++++++++++++++
 tb/tb_picorv32_trace_capture.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/picorv32_trace_capture.sv
// -----------------------------------------------------------------------------
// picorv32_trace_capture
//
// Captures the picorv32 36-bit instruction trace stream into an on-chip FIFO.
// Firmware or a debug master drains the FIFO through a classic Wishbone slave.
//
// Build option:
//   TRACE_CAPTURE_WRAP_EN  defined   : ring mode, a push into a full FIFO
//                                      overwrites the oldest entry.
//                          undefined : first-N mode, a push into a full FIFO
//                                      is discarded.
//   In both modes an overflowing push increments the dropped-sample count.
//
// Parameters:
//   DEPTH_LOG2     FIFO depth is 2**DEPTH_LOG2 entries of 36 bits (2..15)
//
// Ports:
//   clk_i          sole clock
//   rst_i          asynchronous, active-high reset
//   trace_valid_i  trace sample strobe from the core
//   trace_data_i   36-bit trace sample
//   trap_i         core trap indication
//   wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i[3:0], wb_dat_i[31:0], wb_sel_i[3:0]
//                  Wishbone slave inputs (only wb_adr_i[3:2] decoded,
//                  wb_sel_i ignored)
//   wb_dat_o       read data, valid only in the ack cycle, 0 otherwise
//   wb_ack_o       one-cycle access acknowledge
//   irq_o          level interrupt: IRQ_EN and state FROZEN (registered)
//
// Register map (word addresses):
//   0x0 CTRL    W: bit0 ARM, bit1 STOP, bit2 CLEAR (strobes), bit3 IRQ_EN,
//                  bit4 STOP_ON_TRAP
//               R: [1:0] state, bit3 IRQ_EN, bit4 STOP_ON_TRAP, bit8 empty,
//                  bit9 full
//   0x4 DATA_LO R: head sample [31:0], pops; latches [35:32] + valid to DATA_HI
//   0x8 DATA_HI R: [3:0] latched upper bits, [31] latched valid
//   0xC COUNT   R: [15:0] fill level, [31:16] saturating dropped count
// -----------------------------------------------------------------------------
module picorv32_trace_capture #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        trace_valid_i,
    input  logic [35:0] trace_data_i,
    input  logic        trap_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        irq_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   LVL_ONE = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FROZEN  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_DATA_LO = 2'd1,
        REG_DATA_HI = 2'd2,
        REG_COUNT   = 2'd3
    } reg_sel_t;

    state_t                state, state_nx;
    logic                  irq_en;
    logic                  stop_on_trap;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic [15:0]           level16;
    logic [15:0]           dropped;
    logic [4:0]            data_hi;      // {valid, sample[35:32]}
    logic [35:0]           mem [DEPTH];
    logic [35:0]           head;

    // -------------------------------------------------------------------------
    // Wishbone decode. An access is accepted on the first cycle it is
    // requested while no ack is outstanding, so accesses complete at most one
    // every two cycles. All side effects land on the edge that raises the ack.
    // -------------------------------------------------------------------------
    reg_sel_t reg_sel;
    logic     wb_req, wr_fire, rd_fire, ctrl_wr;
    logic     do_arm, do_stop, do_clear;

    assign reg_sel  = reg_sel_t'(wb_adr_i[3:2]);
    assign wb_req   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr_fire  = wb_req & wb_we_i;
    assign rd_fire  = wb_req & ~wb_we_i;
    assign ctrl_wr  = wr_fire & (reg_sel == REG_CTRL);
    assign do_arm   = ctrl_wr & wb_dat_i[0];
    assign do_stop  = ctrl_wr & wb_dat_i[1];
    assign do_clear = ctrl_wr & wb_dat_i[2];

    // Bits the register map does not decode.
    logic unused_bits;
    assign unused_bits = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i[31:5]};

    // -------------------------------------------------------------------------
    // FIFO bookkeeping
    // -------------------------------------------------------------------------
    logic empty, full;
    logic pop, push_req, overflow, mem_we, rd_adv, lvl_inc;

    assign empty    = (level == '0);
    assign full     = level[DEPTH_LOG2];
    assign head     = mem[rd_ptr];
    assign pop      = rd_fire & (reg_sel == REG_DATA_LO) & ~empty;
    // CLEAR wins over a sample arriving on the same edge.
    assign push_req = trace_valid_i & (state == CAPTURE) & ~do_clear;
    // A concurrent pop frees a slot, so push+pop on a full FIFO is no overflow.
    assign overflow = push_req & full & ~pop;
    assign lvl_inc  = push_req & ~overflow;

`ifdef TRACE_CAPTURE_WRAP_EN
    // Ring mode: overwrite the oldest entry and drag the read pointer along.
    assign mem_we = push_req;
    assign rd_adv = pop | overflow;
`else
    // First-N mode: the overflowing sample is simply discarded.
    assign mem_we = lvl_inc;
    assign rd_adv = pop;
`endif

    always_comb begin
        level16                = '0;
        level16[DEPTH_LOG2:0]  = level;
    end

    // NOTE: the sample storage has no reset; its contents are only observable
    // through pointers that are reset, and a reset here would prevent RAM
    // inference.
    always_ff @(posedge clk_i) begin
        if (mem_we)
            mem[wr_ptr] <= trace_data_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            dropped <= '0;
            data_hi <= '0;
        end else if (do_clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            dropped <= '0;
            data_hi <= '0;
        end else begin
            if (mem_we)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_adv)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (lvl_inc && !pop)
                level <= level + LVL_ONE;
            else if (pop && !lvl_inc)
                level <= level - LVL_ONE;
            if (overflow && dropped != 16'hFFFF)
                dropped <= dropped + 16'd1;
            if (rd_fire && reg_sel == REG_DATA_LO)
                data_hi <= empty ? 5'd0 : {1'b1, head[35:32]};
        end
    end

    // -------------------------------------------------------------------------
    // Control registers and state machine
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            irq_en       <= 1'b0;
            stop_on_trap <= 1'b1;
            irq_o        <= 1'b0;
        end else begin
            state <= state_nx;
            if (ctrl_wr) begin
                irq_en       <= wb_dat_i[3];
                stop_on_trap <= wb_dat_i[4];
            end
            // Registered from the current state: rises the cycle after the
            // FROZEN transition and falls the cycle after ARM / IRQ_EN=0.
            irq_o <= irq_en & (state == FROZEN);
        end
    end

    // Strobe priority: CLEAR (no state effect), then STOP, then ARM, so a
    // write of 0x7 ends in CAPTURE. A trap freezes on the edge it is seen.
    // NOTE: combinational blocks assign every output a default first so no
    // path through them infers a latch.
    always_comb begin
        state_nx = state;
        if (state == CAPTURE && (do_stop || (trap_i && stop_on_trap)))
            state_nx = FROZEN;
        if (do_arm)
            state_nx = CAPTURE;
    end

    // -------------------------------------------------------------------------
    // Read mux and Wishbone response
    // -------------------------------------------------------------------------
    logic [31:0] rd_data;

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_CTRL:    rd_data = {22'd0, full, empty, 3'd0, stop_on_trap,
                                    irq_en, 1'b0, state};
            REG_DATA_LO: rd_data = empty ? 32'd0 : head[31:0];
            REG_DATA_HI: rd_data = {data_hi[4], 27'd0, data_hi[3:0]};
            REG_COUNT:   rd_data = {dropped, level16};
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= wb_req;
            wb_dat_o <= rd_fire ? rd_data : 32'd0;
        end
    end

endmodule

// File: tb/tb_picorv32_trace_capture.sv
module tb_picorv32_trace_capture;

    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_valid;
    logic [35:0] trace_data;
    logic        trap;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_adr;
    logic [31:0] wb_dat_w;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_r;
    logic        wb_ack;
    logic        irq;

    int vectors     = 0;
    int miscompares = 0;

    logic [35:0] sb[$];
    logic [15:0] exp_dropped;

    picorv32_trace_capture #(.DEPTH_LOG2(DL2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .trace_valid_i(trace_valid),
        .trace_data_i (trace_data),
        .trap_i       (trap),
        .wb_cyc_i     (wb_cyc),
        .wb_stb_i     (wb_stb),
        .wb_we_i      (wb_we),
        .wb_adr_i     (wb_adr),
        .wb_dat_i     (wb_dat_w),
        .wb_sel_i     (wb_sel),
        .wb_dat_o     (wb_dat_r),
        .wb_ack_o     (wb_ack),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model of one captured sample (only called while CAPTURE).
    task automatic model_push(input logic [35:0] d);
        if (sb.size() < DEPTH) begin
            sb.push_back(d);
        end else begin
            if (exp_dropped != 16'hFFFF) exp_dropped++;
`ifdef TRACE_CAPTURE_WRAP_EN
            void'(sb.pop_front());
            sb.push_back(d);
`endif
        end
    endtask

    task automatic model_clear();
        sb.delete();
        exp_dropped = '0;
    endtask

    task automatic wb_xfer(input logic we, input logic [3:0] adr,
                           input logic [31:0] wdat, output logic [31:0] rdat);
        logic ok;
        ok   = 1'b0;
        rdat = '0;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_w = wdat;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (wb_ack) begin
                rdat = wb_dat_r;
                ok   = 1'b1;
                break;
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL wb_timeout: adr %h got no ack, required ack within 8 cycles", adr);
        end
    endtask

    task automatic wb_read(input logic [3:0] adr, output logic [31:0] rdat);
        wb_xfer(1'b0, adr, 32'd0, rdat);
    endtask

    task automatic wb_write(input logic [3:0] adr, input logic [31:0] wdat);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, wdat, dummy);
    endtask

    task automatic push_sample(input logic [35:0] d, input logic captured);
        trace_valid = 1'b1;
        trace_data  = d;
        tick();
        trace_valid = 1'b0;
        if (captured) model_push(d);
    endtask

    // Scoreboard consumer: one DATA_LO + DATA_HI pair against the model head.
    task automatic pop_compare(input string name);
        logic [31:0] lo, hi, exp_lo, exp_hi;
        logic [35:0] e;
        if (sb.size() > 0) begin
            e      = sb.pop_front();
            exp_lo = e[31:0];
            exp_hi = {1'b1, 27'd0, e[35:32]};
        end else begin
            exp_lo = 32'd0;
            exp_hi = 32'd0;
        end
        wb_read(4'h4, lo);
        wb_read(4'h8, hi);
        vectors++;
        if (lo !== exp_lo) begin
            miscompares++;
            $display("FAIL %s data_lo: got %h required %h", name, lo, exp_lo);
        end
        vectors++;
        if (hi !== exp_hi) begin
            miscompares++;
            $display("FAIL %s data_hi: got %h required %h", name, hi, exp_hi);
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst = 1'b1;
        tick(); tick();
        vectors++;
        if (wb_ack !== 1'b0 || irq !== 1'b0 || wb_dat_r !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ack %b irq %b dat %h required 0 0 0",
                     wb_ack, irq, wb_dat_r);
        end
        rst = 1'b0;
        tick();
        model_clear();
        wb_read(4'h0, r);
        vectors++;
        if (r !== 32'h0000_0110) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %h required %h", r, 32'h0000_0110);
        end
        wb_read(4'hC, r);
        vectors++;
        if (r !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_count: got %h required %h", r, 32'd0);
        end
        tick();
        vectors++;
        if (wb_ack !== 1'b0 || irq !== 1'b0 || wb_dat_r !== 32'd0) begin
            miscompares++;
            $display("FAIL idle_outputs: got ack %b irq %b dat %h required 0 0 0",
                     wb_ack, irq, wb_dat_r);
        end
    endtask

    task automatic test_basic_capture();
        logic [31:0] r;
        push_sample(36'h5_1234_5678, 1'b0);   // IDLE: ignored, not dropped
        wb_write(4'h0, 32'h1);
        push_sample(36'h9_0000_0001, 1'b1);
        push_sample(36'h0_0000_0002, 1'b1);
        push_sample(36'hF_FFFF_FFFF, 1'b1);
        wb_read(4'hC, r);
        vectors++;
        if (r !== {exp_dropped, 16'(sb.size())}) begin
            miscompares++;
            $display("FAIL basic_count: got %h required %h", r, {exp_dropped, 16'(sb.size())});
        end
        for (int i = 0; i < 4; i++) pop_compare("basic");
    endtask

    task automatic test_full();
        logic [31:0] r;
        wb_write(4'h0, 32'h5);                // CLEAR + ARM
        model_clear();
        for (int i = 1; i <= 6; i++) push_sample(36'(i), 1'b1);
        wb_read(4'h0, r);
        vectors++;
        if (r !== 32'h0000_0201) begin
            miscompares++;
            $display("FAIL full_ctrl: got %h required %h", r, 32'h0000_0201);
        end
        wb_read(4'hC, r);
        vectors++;
        if (r !== 32'h0002_0004) begin
            miscompares++;
            $display("FAIL full_count: got %h required %h", r, 32'h0002_0004);
        end
        for (int i = 0; i < 5; i++) pop_compare("full");
    endtask

    task automatic test_push_pop_full();
        logic [31:0] r, exp_lo;
        logic        ack_seen;
        logic [35:0] e;
        wb_write(4'h0, 32'h5);
        model_clear();
        for (int i = 0; i < DEPTH; i++) push_sample(36'h3_0000_0100 + 36'(i), 1'b1);
        // DATA_LO pop and push land on the same edge.
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 4'h4;
        trace_valid = 1'b1; trace_data = 36'hC_0000_0104;
        tick();
        trace_valid = 1'b0;
        ack_seen = wb_ack;
        r = wb_dat_r;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        e = sb.pop_front();
        exp_lo = e[31:0];
        model_push(36'hC_0000_0104);
        vectors++;
        if (ack_seen !== 1'b1 || r !== exp_lo) begin
            miscompares++;
            $display("FAIL pushpop_data: got ack %b data %h required ack 1 data %h",
                     ack_seen, r, exp_lo);
        end
        wb_read(4'hC, r);
        vectors++;
        if (r !== {exp_dropped, 16'(sb.size())} || r !== 32'h0000_0004) begin
            miscompares++;
            $display("FAIL pushpop_count: got %h required %h", r, 32'h0000_0004);
        end
        for (int i = 0; i < DEPTH + 1; i++) pop_compare("pushpop");
    endtask

    task automatic test_trap_freeze();
        logic [31:0] r;
        wb_write(4'h0, 32'h1D);               // CLEAR, ARM, IRQ_EN, STOP_ON_TRAP
        model_clear();
        trace_valid = 1'b1;
        trace_data = 36'h11; tick(); model_push(36'h11);
        trace_data = 36'h12; tick(); model_push(36'h12);
        trace_data = 36'hA; trap = 1'b1; tick(); model_push(36'hA);
        trap = 1'b0;
        trace_data = 36'h13;
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL trap_irq_early: got %b required 0", irq);
        end
        tick();
        trace_valid = 1'b0;
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL trap_irq: got %b required 1", irq);
        end
        wb_read(4'h0, r);
        vectors++;
        if (r !== 32'h0000_001A) begin
            miscompares++;
            $display("FAIL trap_ctrl: got %h required %h", r, 32'h0000_001A);
        end
        wb_read(4'hC, r);
        vectors++;
        if (r !== 32'h0000_0003) begin
            miscompares++;
            $display("FAIL trap_count: got %h required %h", r, 32'h0000_0003);
        end
        for (int i = 0; i < 4; i++) pop_compare("trap");
        wb_write(4'h0, 32'h1);
        tick();
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL trap_irq_clear: got %b required 0", irq);
        end
        wb_read(4'h0, r);
        vectors++;
        if (r !== 32'h0000_0101) begin
            miscompares++;
            $display("FAIL rearm_ctrl: got %h required %h", r, 32'h0000_0101);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] r;
        logic        ack_seen;
        wb_write(4'h0, 32'h5);
        model_clear();
        for (int i = 0; i < 3; i++) push_sample(36'h7_0000_0040 + 36'(i), 1'b1);
        wb_read(4'hC, r);
        vectors++;
        if (r !== 32'h0000_0003) begin
            miscompares++;
            $display("FAIL premid_count: got %h required %h", r, 32'h0000_0003);
        end
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 4'h4;
        #4 rst = 1'b1;
        ack_seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            ack_seen = ack_seen | wb_ack;
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        rst = 1'b0;
        model_clear();
        vectors++;
        if (ack_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_ack: got %b required 0", ack_seen);
        end
        tick();
        wb_read(4'hC, r);
        vectors++;
        if (r !== 32'd0) begin
            miscompares++;
            $display("FAIL midreset_count: got %h required %h", r, 32'd0);
        end
        wb_read(4'h0, r);
        vectors++;
        if (r !== 32'h0000_0110) begin
            miscompares++;
            $display("FAIL midreset_ctrl: got %h required %h", r, 32'h0000_0110);
        end
    endtask

    initial begin
        rst = 1'b1;
        trace_valid = 1'b0; trace_data = '0; trap = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_adr = '0; wb_dat_w = '0; wb_sel = 4'hF;
        exp_dropped = '0;
        test_reset();
        test_basic_capture();
        test_full();
        test_push_pop_full();
        test_trap_freeze();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
